regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file writeback control slice.
//   DW_DEFAULT / AW_DEFAULT : default write-data and register-address widths
//   req_id_e                : requester identity; also the bit position of
//                             each requester in the arbiter request/grant vectors
package regfile_ctrl_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;

  typedef enum logic {
    REQ_A = 1'b0,  // ALU writeback
    REQ_B = 1'b1   // load writeback
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : requests, bit REQ_A / REQ_B
//   xfer     : a granted request was accepted this cycle
//   gnt[1:0] : one-hot (or zero) combinational grant, forced to 0 during reset
// A lone request is granted at once. On a tie the grant goes to the requester
// that did not win the most recent transfer. The pointer moves only on xfer
// and starts at REQ_B so that A wins the first tie after reset.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] gnt
);

  req_id_e last_q;

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_B;
    end else if (xfer) begin
      last_q <= gnt[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
//   clk, rst                   : clock, asynchronous active-high reset
//   issue_valid / issue_addr   : mark a destination register as pending
//   a_valid/a_addr/a_data      : requester A (ALU writeback); a_ready = accepted
//   b_valid/b_addr/b_data      : requester B (load writeback); b_ready = accepted
//   rf_write/rf_waddr/rf_wdata : registered register-file write port
//   q_addr1/2 -> q_busy1/2     : combinational pending lookup (no bypass)
//   conflict_cnt               : saturating count of both-valid cycles
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DW           = DW_DEFAULT,
  parameter int unsigned AW           = AW_DEFAULT,
  parameter bit          ZERO_DISCARD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          rf_write,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic [15:0]   conflict_cnt
);

  localparam int unsigned NREG = 2 ** AW;

  logic [1:0]      gnt;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_drop;
  logic            issue_set;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({b_valid, a_valid}),
    .xfer (xfer),
    .gnt  (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer    = |gnt;

  assign sel_addr  = gnt[1] ? b_addr : a_addr;
  assign sel_data  = gnt[1] ? b_data : a_data;
  assign sel_drop  = ZERO_DISCARD && (sel_addr == '0);
  assign issue_set = issue_valid && !(ZERO_DISCARD && (issue_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_write <= xfer && !sel_drop;
      if (xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Clear is applied before set so a same-edge set on the same address wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_write) begin
      pending_d[rf_waddr] = 1'b0;
    end
    if (issue_set) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign q_busy1 = pending_q[q_addr1];
  assign q_busy2 = pending_q[q_addr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (a_valid && b_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_addr = '0;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          rf_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q_addr1 = '0;
  logic [AW-1:0] q_addr2 = '0;
  logic          q_busy1;
  logic          q_busy2;
  logic [15:0]   conflict_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state (rule level: who last won, which regs are pending,
  // what the write port should show, how many ties have been seen).
  int        m_last;         // 0 = A won last transfer, 1 = B
  bit        m_pend [32];
  bit        m_wr;
  int        m_waddr;
  logic [31:0] m_wdata;
  int        m_cnt;

  // Observations of the most recent cycle, for directed scenario checks.
  bit        acc_a, acc_b;
  logic      obs_a_ready, obs_b_ready, obs_busy1;
  logic [15:0] obs_cnt_pre;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .ZERO_DISCARD(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_last  = 1;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_wr    = 1'b0;
    m_waddr = 0;
    m_wdata = '0;
    m_cnt   = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // One clock cycle. Called just after a falling edge with inputs set; returns
  // at the next falling edge. Checks combinational outputs before the rising
  // edge and registered outputs after it against the model.
  task automatic cycle();
    bit ga, gb;
    int addr;
    logic [31:0] data;
    #1;
    ga = a_valid && (!b_valid || m_last == 1);
    gb = b_valid && !ga;
    obs_a_ready = a_ready;
    obs_b_ready = b_ready;
    obs_busy1   = q_busy1;
    obs_cnt_pre = conflict_cnt;
    checks++;
    if (a_ready !== ga) begin
      failures++;
      $display("FAIL a_ready: got %b expected %b t=%0t", a_ready, ga, $time);
    end
    checks++;
    if (b_ready !== gb) begin
      failures++;
      $display("FAIL b_ready: got %b expected %b t=%0t", b_ready, gb, $time);
    end
    checks++;
    if (q_busy1 !== m_pend[q_addr1] || q_busy2 !== m_pend[q_addr2]) begin
      failures++;
      $display("FAIL q_busy: got %b%b expected %b%b t=%0t", q_busy1, q_busy2,
               m_pend[q_addr1], m_pend[q_addr2], $time);
    end
    @(posedge clk);
    if (m_wr) m_pend[m_waddr] = 1'b0;
    if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    if (a_valid && b_valid && m_cnt != 16'hFFFF) m_cnt++;
    acc_a = ga;
    acc_b = gb;
    if (ga || gb) begin
      addr    = ga ? int'(a_addr) : int'(b_addr);
      data    = ga ? a_data : b_data;
      m_last  = ga ? 0 : 1;
      m_wr    = (addr != 0);
      m_waddr = addr;
      m_wdata = data;
    end else begin
      m_wr = 1'b0;
    end
    #1;
    checks++;
    if (rf_write !== m_wr) begin
      failures++;
      $display("FAIL rf_write: got %b expected %b t=%0t", rf_write, m_wr, $time);
    end
    if (m_wr) begin
      checks++;
      if (rf_waddr !== m_waddr[AW-1:0] || rf_wdata !== m_wdata) begin
        failures++;
        $display("FAIL rf_port: got %0d/%h expected %0d/%h t=%0t", rf_waddr, rf_wdata,
                 m_waddr, m_wdata, $time);
      end
    end
    checks++;
    if (conflict_cnt !== m_cnt[15:0]) begin
      failures++;
      $display("FAIL conflict_cnt: got %0d expected %0d t=%0t", conflict_cnt, m_cnt, $time);
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check the immediate clear, hold, release.
  task automatic apply_reset(input bit check_now);
    rst = 1'b1;
    #1;
    if (check_now) begin
      checks++;
      if (rf_write !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
        failures++;
        $display("FAIL reset_rf: got %b/%0d/%h expected 0/0/0", rf_write, rf_waddr, rf_wdata);
      end
      checks++;
      if (conflict_cnt !== 16'd0) begin
        failures++;
        $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt);
      end
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready: got %b%b expected 00", a_ready, b_ready);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got rdy=%b%b busy=%b%b expected 0000", a_ready, b_ready,
               q_busy1, q_busy2);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    apply_reset(1'b1);
    cycle();
  endtask

  task automatic test_single_a();
    idle_inputs();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    checks++;
    if (obs_a_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_a_ready: got %b expected 1", obs_a_ready);
    end
    checks++;
    if (rf_write !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_a_write: got %b/%0d/%h expected 1/5/deadbeef", rf_write, rf_waddr,
               rf_wdata);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_round_robin();
    string seq;
    idle_inputs();
    apply_reset(1'b0);
    seq = "";
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      seq = {seq, obs_a_ready ? "A" : (obs_b_ready ? "B" : "-")};
      if (acc_a) begin a_addr = a_addr + 5'd1; a_data = a_data + 32'd1; end
      if (acc_b) begin b_addr = b_addr + 5'd1; b_data = b_data + 32'd1; end
    end
    checks++;
    if (seq != "ABA") begin
      failures++;
      $display("FAIL rr_sequence: got %s expected ABA", seq);
    end
    checks++;
    if (obs_cnt_pre !== 16'd2) begin
      failures++;
      $display("FAIL rr_conflict_cnt: got %0d expected 2", obs_cnt_pre);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_pending();
    idle_inputs();
    issue_valid = 1'b1; issue_addr = 5'd7;
    cycle();
    issue_valid = 1'b0; q_addr1 = 5'd7;
    cycle();
    checks++;
    if (obs_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL pending_set: got %b expected 1", obs_busy1);
    end
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    cycle();
    a_valid = 1'b0;
    cycle();  // rf_write=1 for addr 7 during this cycle; still busy
    checks++;
    if (obs_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL pending_no_bypass: got %b expected 1", obs_busy1);
    end
    cycle();
    checks++;
    if (obs_busy1 !== 1'b0) begin
      failures++;
      $display("FAIL pending_clear: got %b expected 0", obs_busy1);
    end
  endtask

  task automatic test_set_wins();
    idle_inputs();
    q_addr1 = 5'd3;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    cycle();
    a_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd3;
    cycle();
    issue_valid = 1'b0;
    cycle();
    checks++;
    if (obs_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got %b expected 1", obs_busy1);
    end
  endtask

  task automatic test_zero_discard();
    idle_inputs();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h12345678;
    cycle();
    checks++;
    if (obs_b_ready !== 1'b1 || rf_write !== 1'b0) begin
      failures++;
      $display("FAIL zero_write: got ready=%b write=%b expected 1/0", obs_b_ready, rf_write);
    end
    b_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    cycle();
    issue_valid = 1'b0; q_addr2 = 5'd0;
    cycle();
    checks++;
    if (q_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL zero_pending: got %b expected 0", q_busy2);
    end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hAAAA;
    b_valid = 1'b1; b_addr = 5'd21; b_data = 32'hBBBB;
    issue_valid = 1'b1; issue_addr = 5'd21;
    cycle();   // A wins, pointer now at A
    issue_valid = 1'b0;
    a_addr = 5'd22;
    #2;
    apply_reset(1'b1);
    // Requests pending at reset are dropped by their requesters.
    idle_inputs();
    cycle();
    checks++;
    if (rf_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop: got %b expected 0", rf_write);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    cycle();
    checks++;
    if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_tie: got %b%b expected 10", obs_a_ready, obs_b_ready);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      // Requesters hold a request until accepted, then maybe issue a new one.
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = AW'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = AW'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_addr  = AW'($urandom_range(0, 31));
      q_addr1     = AW'($urandom_range(0, 31));
      q_addr2     = AW'($urandom_range(0, 31));
      acc_a = 1'b0;
      acc_b = 1'b0;
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    model_reset();
    acc_a = 1'b0;
    acc_b = 1'b0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_pending();
    test_set_wins();
    test_zero_discard();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
